// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external combinational ALU between two requesters.
// Operands are registered for a single EXEC cycle, then the result is held until taken.
module alu_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_opA,
  input  logic [WIDTH-1:0] req0_opB,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_opA,
  input  logic [WIDTH-1:0] req1_opB,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state, state_next;
  logic             last_grant, grant_id;
  logic [OP_W-1:0]  op_reg;
  logic [WIDTH-1:0] opa_reg, opb_reg;
  logic [WIDTH-1:0] result_reg;
  logic             id_reg;
  logic             sel0, sel1, accept;

  // On a tie the requester that did not win last time is selected.
  always_comb begin
    sel0 = req0_valid && (!req1_valid || last_grant);
    sel1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = (state == IDLE) && sel0;
  assign req1_ready = (state == IDLE) && sel1;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      op_reg     <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
      id_reg     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_reg     <= req1_ready ? req1_op  : req0_op;
        opa_reg    <= req1_ready ? req1_opA : req0_opA;
        opb_reg    <= req1_ready ? req1_opB : req0_opB;
        grant_id   <= req1_ready;
        last_grant <= req1_ready;
      end
      if (state == EXEC) begin
        result_reg <= alu_result;
        id_reg     <= grant_id;
      end
    end
  end

  // ALU inputs keep their last latched values outside EXEC.
  assign alu_op     = op_reg;
  assign alu_opA    = opa_reg;
  assign alu_opB    = opb_reg;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id_reg;
  assign rsp_result = result_reg;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an OR/ADD ALU model and per-cycle invariant checks.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_opA, req0_opB, req1_opA, req1_opB;
  logic [2:0] alu_op;
  logic [7:0] alu_opA, alu_opB, alu_result;
  logic       rsp_valid, rsp_id, rsp_ready, busy;
  logic [7:0] rsp_result;

  int errors = 0;
  int checks = 0;
  logic prev_valid = 1'b0;
  logic prev_busy  = 1'b0;

  always #5 clk = ~clk;

  // External ALU: op 1 = OR, anything else = ADD.
  assign alu_result = (alu_op == 3'd1) ? (alu_opA | alu_opB) : (alu_opA + alu_opB);

  alu_arbiter #(.WIDTH(8), .OP_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_opA   (req0_opA),
    .req0_opB   (req0_opB),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_opA   (req1_opA),
    .req1_opB   (req1_opB),
    .alu_op     (alu_op),
    .alu_opA    (alu_opA),
    .alu_opB    (alu_opB),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req0_ready"}, 32'(req0_ready), 0);
    check({tag, " req1_ready"}, 32'(req1_ready), 0);
    check({tag, " alu_op"}, 32'(alu_op), 0);
    check({tag, " alu_opA"}, 32'(alu_opA), 0);
    check({tag, " alu_opB"}, 32'(alu_opB), 0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, " rsp_id"}, 32'(rsp_id), 0);
    check({tag, " rsp_result"}, 32'(rsp_result), 0);
    check({tag, " busy"}, 32'(busy), 0);
  endtask

  // Invariants: never two readies; rsp_valid may only rise out of a busy (EXEC) cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv both_ready", 32'(req0_ready && req1_ready), 0);
      if (rsp_valid && !prev_valid) check("inv rsp_after_exec", 32'(prev_busy), 1);
    end
    prev_valid <= rsp_valid;
    prev_busy  <= busy;
  end

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_op = 0; req0_opA = 0; req0_opB = 0;
    req1_op = 0; req1_opA = 0; req1_opB = 0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // 1: single request from req0, 15 | 3.
    req0_valid = 1; req0_op = 1; req0_opA = 15; req0_opB = 3;
    #1;
    check("t1 req0_ready", 32'(req0_ready), 1);
    check("t1 req1_ready", 32'(req1_ready), 0);
    tick();
    req0_valid = 0;
    check("t1 exec busy", 32'(busy), 1);
    check("t1 exec rsp_valid", 32'(rsp_valid), 0);
    check("t1 alu_op", 32'(alu_op), 1);
    check("t1 alu_opA", 32'(alu_opA), 15);
    check("t1 alu_opB", 32'(alu_opB), 3);
    tick();
    check("t1 rsp_valid", 32'(rsp_valid), 1);
    check("t1 rsp_id", 32'(rsp_id), 0);
    check("t1 rsp_result", 32'(rsp_result), 15);
    check("t1 resp busy", 32'(busy), 1);
    tick();
    check("t1 idle rsp_valid", 32'(rsp_valid), 0);
    check("t1 idle busy", 32'(busy), 0);
    check("t1 alu_opA held", 32'(alu_opA), 15);

    // 2: tie right after reset -> req0 first, then req1.
    rst = 1; #2; rst = 0;
    req0_valid = 1; req0_op = 1; req0_opA = 15; req0_opB = 3;
    req1_valid = 1; req1_op = 0; req1_opA = 10; req1_opB = 20;
    #1;
    check("t2 tie req0_ready", 32'(req0_ready), 1);
    check("t2 tie req1_ready", 32'(req1_ready), 0);
    tick();
    req0_valid = 0;
    check("t2 exec req1_ready", 32'(req1_ready), 0);
    tick();
    check("t2 rsp0 id", 32'(rsp_id), 0);
    check("t2 rsp0 result", 32'(rsp_result), 15);
    check("t2 resp req1_ready", 32'(req1_ready), 0);
    tick();
    check("t2 idle req1_ready", 32'(req1_ready), 1);
    tick();
    req1_valid = 0;
    check("t2 alu_op", 32'(alu_op), 0);
    check("t2 alu_opA", 32'(alu_opA), 10);
    tick();
    check("t2 rsp1 valid", 32'(rsp_valid), 1);
    check("t2 rsp1 id", 32'(rsp_id), 1);
    check("t2 rsp1 result", 32'(rsp_result), 30);
    tick();

    // 3: next tie goes to req0; then back-pressure in RESP.
    req0_valid = 1; req0_op = 0; req0_opA = 100; req0_opB = 55;
    req1_valid = 1; req1_op = 1; req1_opA = 240; req1_opB = 15;
    rsp_ready = 0;
    #1;
    check("t3 tie req0_ready", 32'(req0_ready), 1);
    check("t3 tie req1_ready", 32'(req1_ready), 0);
    tick();
    req0_valid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3 hold rsp_valid", 32'(rsp_valid), 1);
      check("t3 hold rsp_result", 32'(rsp_result), 155);
      check("t3 hold rsp_id", 32'(rsp_id), 0);
      check("t3 hold req1_ready", 32'(req1_ready), 0);
      check("t3 hold req0_ready", 32'(req0_ready), 0);
      tick();
    end
    rsp_ready = 1;
    #1;
    check("t3 still valid", 32'(rsp_valid), 1);
    tick();
    check("t3 released rsp_valid", 32'(rsp_valid), 0);
    check("t3 resume req1_ready", 32'(req1_ready), 1);

    // 4: reset during EXEC of req1 (240 | 15) discards the response.
    tick();
    req1_valid = 0;
    check("t4 exec busy", 32'(busy), 1);
    check("t4 alu_opA", 32'(alu_opA), 240);
    #2;
    rst = 1;
    #1;
    check_reset_outputs("t4 async");
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      check("t4 no rsp_valid", 32'(rsp_valid), 0);
      check("t4 no 255", 32'(rsp_result == 8'd255), 0);
      tick();
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    check("t4 tie req0_ready", 32'(req0_ready), 1);
    check("t4 tie req1_ready", 32'(req1_ready), 0);
    req0_valid = 0; req1_valid = 0;
    tick();
    check("t4 no accept", 32'(busy), 0);

    // 5: only req1 valid, back-to-back ORs with 128.
    req1_valid = 1; req1_op = 1; req1_opA = 1; req1_opB = 128;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("t5 req1_ready", 32'(req1_ready), 1);
      tick();
      req1_opA = 8'(i + 1);
      if (i == 4) req1_valid = 0;
      check("t5 exec req1_ready", 32'(req1_ready), 0);
      tick();
      check("t5 rsp_id", 32'(rsp_id), 1);
      check("t5 rsp_result", 32'(rsp_result), 32'(128 + i));
      check("t5 resp req1_ready", 32'(req1_ready), 0);
      tick();
    end
    check("t5 final idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
